data_memory_arbiter: RTL and testbench



---
 rtl/data_memory_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_arbiter
//  Purpose  : Shares a single-port data memory between the core load/store
//             path (port 0) and a debug/loader master (port 1). Round-robin
//             arbitration with optional bounded burst locking; the granted
//             access completes in the same cycle, and read data is returned
//             registered one cycle later.
//  Ports    : clk, reset (async, active high)
//             Req/Write/Lock/Address/Write_Data _x_i  : requester x inputs
//             Grant_x_o       : access performed for port x this cycle
//             Read_Valid_x_o  : one-cycle pulse, read data for port x valid
//             Read_Data_x_o   : last read data for port x (held)
//             Core_Stall_o    : port 0 requesting but not granted
//             Mem_Write_o / Mem_Read_o / Mem_Address_o / Mem_Write_Data_o
//                             : memory drive for the granted port
//             Mem_Read_Data_i : combinational read data from memory
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // port 0 : core
  input  logic                  Req_0_i,
  input  logic                  Write_0_i,
  input  logic                  Lock_0_i,
  input  logic [ADDR_WIDTH-1:0] Address_0_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_0_i,
  output logic                  Grant_0_o,
  output logic                  Read_Valid_0_o,
  output logic [DATA_WIDTH-1:0] Read_Data_0_o,
  // port 1 : debug / loader
  input  logic                  Req_1_i,
  input  logic                  Write_1_i,
  input  logic                  Lock_1_i,
  input  logic [ADDR_WIDTH-1:0] Address_1_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_1_i,
  output logic                  Grant_1_o,
  output logic                  Read_Valid_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  // core control
  output logic                  Core_Stall_o,
  // memory side
  output logic                  Mem_Write_o,
  output logic                  Mem_Read_o,
  output logic [ADDR_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Write_Data_o,
  input  logic [DATA_WIDTH-1:0] Mem_Read_Data_i
);

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q,      owner_d;
  logic                  locked_q,     locked_d;
  logic [3:0]            burst_cnt_q,  burst_cnt_d;
  logic                  rd_pend_0_q,  rd_pend_0_d;
  logic                  rd_pend_1_q,  rd_pend_1_d;
  logic [DATA_WIDTH-1:0] rdata_0_q,    rdata_0_d;
  logic [DATA_WIDTH-1:0] rdata_1_q,    rdata_1_d;

  logic w_gnt_0;
  logic w_gnt_1;
  logic w_owner_req;
  logic w_gnt_lock;

  // --------------------------------------------------------------------------
  // Grant decision
  // --------------------------------------------------------------------------
  assign w_owner_req = owner_q ? Req_1_i : Req_0_i;

  always_comb begin
    w_gnt_0 = 1'b0;
    w_gnt_1 = 1'b0;
    // No access may reach memory while reset is held.
    if (!reset) begin
      if (locked_q && w_owner_req && (burst_cnt_q < c_max_burst)) begin
        w_gnt_0 = ~owner_q;
        w_gnt_1 = owner_q;
      end else if (Req_0_i && !Req_1_i) begin
        w_gnt_0 = 1'b1;
      end else if (Req_1_i && !Req_0_i) begin
        w_gnt_1 = 1'b1;
      end else if (Req_0_i && Req_1_i) begin
        // Tie (also reached once a burst is exhausted): the port that did
        // not win last time gets the slot.
        w_gnt_0 = last_grant_q;
        w_gnt_1 = ~last_grant_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Memory drive
  // --------------------------------------------------------------------------
  always_comb begin
    Mem_Write_o      = 1'b0;
    Mem_Read_o       = 1'b0;
    Mem_Address_o    = '0;
    Mem_Write_Data_o = '0;
    if (w_gnt_0) begin
      Mem_Write_o      = Write_0_i;
      Mem_Read_o       = ~Write_0_i;
      Mem_Address_o    = Address_0_i;
      Mem_Write_Data_o = Write_Data_0_i;
    end else if (w_gnt_1) begin
      Mem_Write_o      = Write_1_i;
      Mem_Read_o       = ~Write_1_i;
      Mem_Address_o    = Address_1_i;
      Mem_Write_Data_o = Write_Data_1_i;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state: round-robin pointer, lock tracking, read return
  // --------------------------------------------------------------------------
  assign w_gnt_lock = w_gnt_1 ? Lock_1_i : Lock_0_i;

  always_comb begin
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    locked_d     = locked_q;
    burst_cnt_d  = burst_cnt_q;

    if (w_gnt_0 || w_gnt_1) begin
      last_grant_d = w_gnt_1;
      if (w_gnt_lock) begin
        locked_d = 1'b1;
        owner_d  = w_gnt_1;
        if (locked_q && (owner_q == w_gnt_1)) begin
          // Saturate so an uncontested lock never wraps back into the
          // "below limit" range.
          burst_cnt_d = (burst_cnt_q >= c_max_burst) ? c_max_burst
                                                     : burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = 4'd1;
        end
      end else begin
        locked_d    = 1'b0;
        burst_cnt_d = 4'd0;
      end
    end else if (locked_q) begin
      // No grant while locked means the owner dropped its request.
      locked_d    = 1'b0;
      burst_cnt_d = 4'd0;
    end

    rd_pend_0_d = w_gnt_0 & ~Write_0_i;
    rd_pend_1_d = w_gnt_1 & ~Write_1_i;
    rdata_0_d   = rd_pend_0_d ? Mem_Read_Data_i : rdata_0_q;
    rdata_1_d   = rd_pend_1_d ? Mem_Read_Data_i : rdata_1_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      locked_q     <= 1'b0;
      burst_cnt_q  <= 4'd0;
      rd_pend_0_q  <= 1'b0;
      rd_pend_1_q  <= 1'b0;
      rdata_0_q    <= '0;
      rdata_1_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      locked_q     <= locked_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_pend_0_q  <= rd_pend_0_d;
      rd_pend_1_q  <= rd_pend_1_d;
      rdata_0_q    <= rdata_0_d;
      rdata_1_q    <= rdata_1_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign Grant_0_o      = w_gnt_0;
  assign Grant_1_o      = w_gnt_1;
  assign Read_Valid_0_o = rd_pend_0_q;
  assign Read_Valid_1_o = rd_pend_1_q;
  assign Read_Data_0_o  = rdata_0_q;
  assign Read_Data_1_o  = rdata_1_q;
  assign Core_Stall_o   = Req_0_i & ~w_gnt_0;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_arbiter
//  Purpose  : Self-checking bench for data_memory_arbiter: directed vector
//             table, hand-written lock/reset sequences and randomized traffic
//             compared against a rule-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk;
  logic        reset;
  logic        Req_0_i, Write_0_i, Lock_0_i;
  logic [31:0] Address_0_i, Write_Data_0_i;
  logic        Grant_0_o, Read_Valid_0_o;
  logic [31:0] Read_Data_0_o;
  logic        Req_1_i, Write_1_i, Lock_1_i;
  logic [31:0] Address_1_i, Write_Data_1_i;
  logic        Grant_1_o, Read_Valid_1_o;
  logic [31:0] Read_Data_1_o;
  logic        Core_Stall_o, Mem_Write_o, Mem_Read_o;
  logic [31:0] Mem_Address_o, Mem_Write_Data_o, Mem_Read_Data_i;

  data_memory_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .Req_0_i(Req_0_i), .Write_0_i(Write_0_i), .Lock_0_i(Lock_0_i),
    .Address_0_i(Address_0_i), .Write_Data_0_i(Write_Data_0_i),
    .Grant_0_o(Grant_0_o), .Read_Valid_0_o(Read_Valid_0_o), .Read_Data_0_o(Read_Data_0_o),
    .Req_1_i(Req_1_i), .Write_1_i(Write_1_i), .Lock_1_i(Lock_1_i),
    .Address_1_i(Address_1_i), .Write_Data_1_i(Write_Data_1_i),
    .Grant_1_o(Grant_1_o), .Read_Valid_1_o(Read_Valid_1_o), .Read_Data_1_o(Read_Data_1_o),
    .Core_Stall_o(Core_Stall_o),
    .Mem_Write_o(Mem_Write_o), .Mem_Read_o(Mem_Read_o),
    .Mem_Address_o(Mem_Address_o), .Mem_Write_Data_o(Mem_Write_Data_o),
    .Mem_Read_Data_i(Mem_Read_Data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Data memory attached to the DUT (updated only from the DUT's pins)
  // --------------------------------------------------------------------------
  function automatic logic [31:0] init_word(input int i);
    if (i == 'h10) return 32'hDEAD_BEEF;
    if (i == 'h20) return 32'h1234_5678;
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  logic [31:0] mem [256];
  bit          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (Mem_Write_o) begin
      mem[Mem_Address_o[7:0]] <= Mem_Write_Data_o;
    end
  end

  assign Mem_Read_Data_i = mem[Mem_Address_o[7:0]];

  // --------------------------------------------------------------------------
  // Check bookkeeping
  // --------------------------------------------------------------------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // --------------------------------------------------------------------------
  // Reference model: arbitration rules applied to plain variables
  // --------------------------------------------------------------------------
  int          m_last, m_owner, m_cnt;
  bit          m_locked, m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] ref_mem [256];

  function automatic void model_reset();
    m_last = 1; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
  endfunction

  // Returns the winning port, or -1 when nobody is granted.
  function automatic int model_winner(input bit r0, input bit r1);
    bit owner_req;
    owner_req = (m_owner == 1) ? r1 : r0;
    if (m_locked && owner_req && m_cnt < MAX_BURST) return m_owner;
    if (r0 && r1) return 1 - m_last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  typedef struct packed {
    bit          rst;                      // reset before applying this row
    bit          tbl;                      // compare the expected fields
    bit          r0, w0, l0;
    logic [31:0] a0, d0;
    bit          r1, w1, l1;
    logic [31:0] a1, d1;
    bit          g0, g1, st, rv0, crd;
    logic [31:0] rd0;
  } row_t;

  function automatic row_t mk(input bit rst,
                              input bit r0, input bit w0, input bit l0,
                              input logic [31:0] a0, input logic [31:0] d0,
                              input bit r1, input bit w1, input bit l1,
                              input logic [31:0] a1, input logic [31:0] d1,
                              input bit g0, input bit g1, input bit st, input bit rv0,
                              input bit crd, input logic [31:0] rd0);
    row_t r;
    r.rst = rst; r.tbl = 1'b1;
    r.r0 = r0; r.w0 = w0; r.l0 = l0; r.a0 = a0; r.d0 = d0;
    r.r1 = r1; r.w1 = w1; r.l1 = l1; r.a1 = a1; r.d1 = d1;
    r.g0 = g0; r.g1 = g1; r.st = st; r.rv0 = rv0; r.crd = crd; r.rd0 = rd0;
    return r;
  endfunction

  function automatic void model_step(input row_t r, input int w);
    bit          wr, lk;
    logic [31:0] a, d;
    if (w >= 0) begin
      wr = (w == 0) ? r.w0 : r.w1;
      lk = (w == 0) ? r.l0 : r.l1;
      a  = (w == 0) ? r.a0 : r.a1;
      d  = (w == 0) ? r.d0 : r.d1;
      m_rv0 = (w == 0) && !wr;
      m_rv1 = (w == 1) && !wr;
      if (wr) ref_mem[a[7:0]] = d;
      else if (w == 0) m_rd0 = ref_mem[a[7:0]];
      else m_rd1 = ref_mem[a[7:0]];
      if (lk) begin
        if (m_locked && m_owner == w) m_cnt = (m_cnt >= MAX_BURST) ? MAX_BURST : m_cnt + 1;
        else m_cnt = 1;
        m_locked = 1'b1;
        m_owner  = w;
      end else begin
        m_locked = 1'b0;
        m_cnt    = 0;
      end
      m_last = w;
    end else begin
      m_rv0 = 1'b0;
      m_rv1 = 1'b0;
      m_locked = 1'b0;
      m_cnt    = 0;
    end
  endfunction

  // --------------------------------------------------------------------------
  // Drivers
  // --------------------------------------------------------------------------
  task automatic idle_inputs();
    Req_0_i = 0; Write_0_i = 0; Lock_0_i = 0; Address_0_i = '0; Write_Data_0_i = '0;
    Req_1_i = 0; Write_1_i = 0; Lock_1_i = 0; Address_1_i = '0; Write_Data_1_i = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Called at posedge+1; applies one cycle, checks at negedge, returns at posedge+1.
  task automatic run_row(input row_t r);
    int          w;
    bit          ew;
    logic [31:0] ea, ed;
    Req_0_i = r.r0; Write_0_i = r.w0; Lock_0_i = r.l0; Address_0_i = r.a0; Write_Data_0_i = r.d0;
    Req_1_i = r.r1; Write_1_i = r.w1; Lock_1_i = r.l1; Address_1_i = r.a1; Write_Data_1_i = r.d1;
    @(negedge clk);
    w  = model_winner(r.r0, r.r1);
    ew = (w == 0) ? r.w0 : r.w1;
    ea = (w == 0) ? r.a0 : r.a1;
    ed = (w == 0) ? r.d0 : r.d1;
    chk1 ("grant_0",    Grant_0_o,        w == 0);
    chk1 ("grant_1",    Grant_1_o,        w == 1);
    chk1 ("core_stall", Core_Stall_o,     r.r0 && (w != 0));
    chk1 ("mem_write",  Mem_Write_o,      (w >= 0) && ew);
    chk1 ("mem_read",   Mem_Read_o,       (w >= 0) && !ew);
    chk32("mem_addr",   Mem_Address_o,    (w >= 0) ? ea : 32'h0);
    chk32("mem_wdata",  Mem_Write_Data_o, (w >= 0) ? ed : 32'h0);
    chk1 ("rvalid_0",   Read_Valid_0_o,   m_rv0);
    chk1 ("rvalid_1",   Read_Valid_1_o,   m_rv1);
    chk32("rdata_0",    Read_Data_0_o,    m_rd0);
    chk32("rdata_1",    Read_Data_1_o,    m_rd1);
    if (r.tbl) begin
      chk1("tbl_grant_0",  Grant_0_o,      r.g0);
      chk1("tbl_grant_1",  Grant_1_o,      r.g1);
      chk1("tbl_stall",    Core_Stall_o,   r.st);
      chk1("tbl_rvalid_0", Read_Valid_0_o, r.rv0);
      if (r.crd) chk32("tbl_rdata_0", Read_Data_0_o, r.rd0);
    end
    model_step(r, w);
    @(posedge clk); #1;
  endtask

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  row_t tbl [10];
  row_t rr;

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    model_reset();

    //            rst r0 w0 l0 a0     d0       r1 w1 l1 a1     d1        g0 g1 st rv0 crd rd0
    // single core read, data back one cycle later
    tbl[0] = mk(1, 1, 0, 0, 'h10, 0,       0, 0, 0, 0,     0,        1, 0, 0, 0, 0, 0);
    tbl[1] = mk(0, 0, 0, 0, 0,    0,       0, 0, 0, 0,     0,        0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    // both request, no lock: 0,1,0,1
    tbl[2] = mk(1, 1, 0, 0, 'h30, 0,       1, 0, 0, 'h31,  0,        1, 0, 0, 0, 0, 0);
    tbl[3] = mk(0, 1, 0, 0, 'h30, 0,       1, 0, 0, 'h31,  0,        0, 1, 1, 1, 0, 0);
    tbl[4] = mk(0, 1, 0, 0, 'h30, 0,       1, 0, 0, 'h31,  0,        1, 0, 0, 0, 0, 0);
    tbl[5] = mk(0, 1, 0, 0, 'h30, 0,       1, 0, 0, 'h31,  0,        0, 1, 1, 1, 0, 0);
    // read vs. write to the same word
    tbl[6] = mk(1, 1, 0, 0, 'h20, 0,       1, 1, 0, 'h20,  32'hAA,   1, 0, 0, 0, 0, 0);
    tbl[7] = mk(0, 0, 0, 0, 0,    0,       1, 1, 0, 'h20,  32'hAA,   0, 1, 0, 1, 1, 32'h1234_5678);
    tbl[8] = mk(0, 1, 0, 0, 'h20, 0,       0, 0, 0, 0,     0,        1, 0, 0, 0, 0, 0);
    tbl[9] = mk(0, 0, 0, 0, 0,    0,       0, 0, 0, 0,     0,        0, 0, 0, 1, 1, 32'h0000_00AA);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].rst) do_reset();
      run_row(tbl[i]);
    end

    // Bounded burst: port 1 locks while both request
    do_reset();
    run_row(mk(0, 1, 0, 0, 'h40, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      run_row(mk(0, 1, 0, 0, 'h41, 0,  1, 0, 1, 'h42, 0,  0, 1, 1, (i == 0), 0, 0));
    run_row(mk(0, 1, 0, 0, 'h41, 0,  1, 0, 1, 'h42, 0,  1, 0, 0, 0, 0, 0));

    // Uncontested lock saturates; a newcomer then wins at once
    do_reset();
    for (int i = 0; i < 10; i++)
      run_row(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 'h50, 0,  0, 1, 0, 0, 0, 0));
    chk32("burst_saturated", 32'(dut.burst_cnt_q), 32'd4);
    run_row(mk(0, 1, 0, 0, 'h51, 0,  1, 0, 1, 'h50, 0,  1, 0, 0, 0, 0, 0));

    // Owner drops request: lock released, tie goes round-robin
    do_reset();
    run_row(mk(0, 0, 0, 0, 0, 0,  1, 0, 1, 'h60, 0,  0, 1, 0, 0, 0, 0));
    run_row(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0,    0,  0, 0, 0, 0, 0, 0));
    run_row(mk(0, 1, 0, 0, 'h61, 0,  1, 0, 1, 'h60, 0,  1, 0, 0, 0, 0, 0));

    // Reset in the cycle after a granted read
    do_reset();
    run_row(mk(0, 1, 0, 0, 'h10, 0,  0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0));
    chk1("pre_rst_rvalid_0", Read_Valid_0_o, 1'b1);
    reset = 1'b1;
    #1;
    chk1 ("rst_rvalid_0", Read_Valid_0_o, 1'b0);
    chk1 ("rst_grant_0",  Grant_0_o,      1'b0);
    chk1 ("rst_mem_read", Mem_Read_o,     1'b0);
    chk1 ("rst_mem_write",Mem_Write_o,    1'b0);
    chk32("rst_mem_addr", Mem_Address_o,  32'h0);
    chk32("rst_rdata_0",  Read_Data_0_o,  32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    run_row(mk(0, 1, 0, 0, 'h70, 0,  1, 0, 0, 'h71, 0,  1, 0, 0, 0, 0, 0));

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      rr     = '0;
      rr.r0  = ($urandom_range(0, 3) != 0);
      rr.w0  = $urandom_range(0, 1) == 1;
      rr.l0  = ($urandom_range(0, 9) < 4);
      rr.a0  = 32'($urandom_range(0, 15));
      rr.d0  = $urandom;
      rr.r1  = ($urandom_range(0, 4) < 3);
      rr.w1  = $urandom_range(0, 1) == 1;
      rr.l1  = ($urandom_range(0, 9) < 7);
      rr.a1  = 32'($urandom_range(0, 15));
      rr.d1  = $urandom;
      run_row(rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
